// File: rtl/mul_booth_csa_seq.sv
// Iterative radix-4 Booth multiplier: one partial product per cycle folded into
// a carry-save sum/carry pair, then a single carry-propagate add for the product.
module mul_booth_csa_seq #(
    parameter int XLEN = 32,
    parameter int NPP  = (XLEN + 2) / 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*XLEN-1:0] out_prod,
    output logic              busy
);

    localparam int PW = 2 * XLEN;
    localparam int CW = $clog2(NPP + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

    state_t                  state;
    logic signed [XLEN:0]    a_q;
    logic        [XLEN+2:0]  b_q;
    logic        [PW-1:0]    sum_reg;
    logic        [PW-1:0]    carry_reg;
    logic        [CW-1:0]    cnt;

    logic        [XLEN+2:0]  b_sh;
    logic        [2:0]       grp;
    logic        [PW-1:0]    pp;
    logic        [PW-1:0]    maj;

    // Multiple of the sign-extended multiplicand selected by one Booth digit, placed at weight 4^idx.
    function automatic logic [PW-1:0] booth_pp(input logic [2:0] g,
                                               input logic signed [XLEN:0] a,
                                               input logic [CW-1:0] idx);
        logic signed [PW-1:0] ae;
        logic        [PW-1:0] m;
        ae = {{(PW-XLEN-1){a[XLEN]}}, a};
        case (g)
            3'b001, 3'b010: m = ae;
            3'b011:         m = ae <<< 1;
            3'b100:         m = -(ae <<< 1);
            3'b101, 3'b110: m = -ae;
            default:        m = '0;
        endcase
        return m << {idx, 1'b0};
    endfunction

    always_comb begin
        b_sh = b_q >> {cnt, 1'b0};
        grp  = b_sh[2:0];
        pp   = booth_pp(grp, a_q, cnt);
        maj  = (sum_reg & carry_reg) | (sum_reg & pp) | (carry_reg & pp);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_prod  <= '0;
            sum_reg   <= '0;
            carry_reg <= '0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else if (flush && state != IDLE) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        a_q       <= {in_signed & in_a[XLEN-1], in_a};
                        b_q       <= {{2{in_signed & in_b[XLEN-1]}}, in_b, 1'b0};
                        sum_reg   <= '0;
                        carry_reg <= '0;
                        cnt       <= '0;
                        state     <= ACCUM;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ACCUM: begin
                    // 3:2 compression; the carry out of bit 63 has weight 2^64 and is dropped.
                    sum_reg   <= sum_reg ^ carry_reg ^ pp;
                    carry_reg <= {maj[PW-2:0], 1'b0};
                    cnt       <= cnt + 1'b1;
                    if (cnt == CW'(NPP - 1))
                        state <= FINAL;
                end
                FINAL: begin
                    out_prod  <= sum_reg + carry_reg;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_booth_csa_seq.sv
// Directed bench for mul_booth_csa_seq: known products, latency, backpressure,
// flush, asynchronous reset and a short run against a 64-bit reference multiply.
module tb_mul_booth_csa_seq;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prod;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mul_booth_csa_seq dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits (bounded) for out_valid; optionally acknowledges it.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit ack, output logic [63:0] prod, output int lat);
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        prod = out_prod;
        if (ack && out_valid) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (out_prod !== 64'h0) begin errors++; $display("FAIL reset_out_prod got %h want 0", out_prod); end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_unsigned();
        logic [63:0] p;
        int lat;
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, p, lat);
        checks++; if (lat !== 18) begin errors++; $display("FAIL unsigned_latency got %0d want 18", lat); end
        checks++; if (p !== 64'hFFFFFFFE00000001) begin errors++; $display("FAIL unsigned_max got %h want fffffffe00000001", p); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL unsigned_idle got ready %b busy %b want 1 0", in_ready, busy); end
    endtask

    task automatic test_signed();
        logic [63:0] p;
        int lat;
        do_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, p, lat);
        checks++; if (p !== 64'h4000000000000000) begin errors++; $display("FAIL signed_min got %h want 4000000000000000", p); end
        do_op(32'hFFFFFFFF, 32'h00000007, 1'b1, 1'b1, p, lat);
        checks++; if (p !== 64'hFFFFFFFFFFFFFFF9) begin errors++; $display("FAIL signed_mixed got %h want fffffffffffffff9", p); end
        do_op(32'hFFFFFFFF, 32'h00000007, 1'b0, 1'b1, p, lat);
        checks++; if (p !== 64'h00000006FFFFFFF9) begin errors++; $display("FAIL unsigned_mixed got %h want 00000006fffffff9", p); end
        do_op(32'h00000000, 32'h12345678, 1'b1, 1'b1, p, lat);
        checks++; if (p !== 64'h0) begin errors++; $display("FAIL zero_operand got %h want 0", p); end
    endtask

    task automatic test_backpressure();
        logic [63:0] p;
        int lat;
        do_op(32'h00010000, 32'h00010001, 1'b0, 1'b0, p, lat);
        checks++; if (p !== 64'h0000000100010000) begin errors++; $display("FAIL bp_prod got %h want 0000000100010000", p); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_prod !== 64'h0000000100010000 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid %b prod %h ready %b want 1 0000000100010000 0",
                         i, out_valid, out_prod, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid %b ready %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_flush();
        logic [63:0] p;
        int lat;
        bit seen;
        in_a = 32'h0000FFFF; in_b = 32'h0000FFFF; in_signed = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle got ready %b busy %b valid %b want 1 0 0", in_ready, busy, out_valid); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_product got valid seen %b want 0", seen); end
        // A flush on the request cycle in IDLE must block acceptance.
        in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle_block got ready %b busy %b want 1 0", in_ready, busy); end
        do_op(32'd3, 32'd5, 1'b0, 1'b1, p, lat);
        checks++; if (p !== 64'd15) begin errors++; $display("FAIL flush_next_op got %h want f", p); end
        checks++; if (lat !== 18) begin errors++; $display("FAIL flush_next_latency got %0d want 18", lat); end
    endtask

    task automatic test_async_reset();
        logic [63:0] p;
        int lat;
        in_a = 32'h12345678; in_b = 32'h9ABCDEF0; in_signed = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset got valid %b busy %b ready %b want 0 0 1", out_valid, busy, in_ready); end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        do_op(32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b1, p, lat);
        checks++; if (p !== 64'hFFFFFFFFFFFFFFFA) begin errors++; $display("FAIL after_reset_op got %h want fffffffffffffffa", p); end
    endtask

    task automatic test_random();
        logic [63:0] p;
        logic [63:0] exp;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int lat;
        for (int i = 0; i < 100; i++) begin
            a = $urandom();
            b = $urandom();
            s = i[0];
            if (s) exp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            else   exp = {32'h0, a} * {32'h0, b};
            do_op(a, b, s, 1'b1, p, lat);
            checks++;
            if (p !== exp || lat !== 18) begin
                errors++;
                $display("FAIL random a %h b %h s %b got %h lat %0d want %h lat 18", a, b, s, p, lat, exp);
            end
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
